// File: rtl/kbd_scancode_fifo_pkg.sv
// kbd_pkg: shared port addresses, command codes and status-bit layout for the keyboard FIFO
package kbd_pkg;
  localparam logic [15:0] KBD_DATA_PORT = 16'h0060;
  localparam logic [15:0] KBD_STAT_PORT = 16'h0064;
  localparam logic [7:0] KBD_CMD_FLUSH = 8'hFF;
  localparam int STAT_OBF = 0;
  localparam int STAT_OVF = 1;
  localparam int STAT_F0 = 2;
  function automatic logic [7:0] stat_byte(input logic f0, input logic ovf, input logic obf);
    stat_byte = '0;
    stat_byte[STAT_F0] = f0;
    stat_byte[STAT_OVF] = ovf;
    stat_byte[STAT_OBF] = obf;
  endfunction
endpackage

// File: rtl/kbd_scancode_fifo_if.sv
// kbd_scancode_fifo_if: PS/2 receive strobe plus CPU port bus seen by the keyboard FIFO
interface kbd_scancode_fifo_if #(parameter int DEPTH_LOG2 = 4);
  logic [7:0] ps2_data;
  logic ps2_data_clk;
  logic [15:0] port_addr;
  logic port_read;
  logic port_clk;
  logic [7:0] port_out;
  logic [7:0] port_in;
  logic kbd_irq;
  logic [DEPTH_LOG2:0] fifo_count;
  modport master(output ps2_data, ps2_data_clk, port_addr, port_read, port_clk, port_out,
                 input port_in, kbd_irq, fifo_count);
  modport slave(input ps2_data, ps2_data_clk, port_addr, port_read, port_clk, port_out,
                output port_in, kbd_irq, fifo_count);
endinterface

// File: rtl/kbd_scancode_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with extra pointer bit for occupancy; push allowed when full only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    full = count[DEPTH_LOG2];
    empty = count == '0;
    do_push = push & ~flush & (~full | pop);
    do_pop = pop & ~flush & ~empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + (DEPTH_LOG2+1)'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + (DEPTH_LOG2+1)'(do_pop);
    dout = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
endmodule

// File: rtl/kbd_scancode_fifo.sv
// kbd_scancode_fifo: queues PS/2 bytes and exposes them as an i8042-style data/status port pair
module kbd_scancode_fifo import kbd_pkg::*; #(
  parameter int DEPTH_LOG2 = 4,
  parameter logic [15:0] DATA_PORT = KBD_DATA_PORT,
  parameter logic [15:0] STAT_PORT = KBD_STAT_PORT
) (
  input logic clock50,
  input logic reset,
  kbd_scancode_fifo_if.slave bus
);
  logic port_read_q, port_clk_q;
  logic rd_edge, wr_edge, data_rd, stat_rd, flush, pop, ovf_set;
  logic overflow_q, overflow_d, f0_seen_q, f0_seen_d, irq_q;
  logic [7:0] port_in_q, port_in_d, last_data_q, last_data_d, dout;
  logic [DEPTH_LOG2:0] count;
  logic full, empty;
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clock50), .rst(reset), .push(bus.ps2_data_clk), .pop(data_rd), .flush(flush),
    .din(bus.ps2_data), .dout(dout), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    rd_edge = bus.port_read & ~port_read_q;
    wr_edge = bus.port_clk & ~port_clk_q;
    data_rd = rd_edge & (bus.port_addr == DATA_PORT);
    stat_rd = rd_edge & (bus.port_addr == STAT_PORT);
    flush = wr_edge & (bus.port_addr == STAT_PORT) & (bus.port_out == KBD_CMD_FLUSH);
    pop = data_rd & ~empty;
    ovf_set = bus.ps2_data_clk & full & ~pop & ~flush;
    overflow_d = flush ? 1'b0 : ovf_set ? 1'b1 : stat_rd ? 1'b0 : overflow_q;
    f0_seen_d = flush ? 1'b0 : bus.ps2_data_clk ? (bus.ps2_data == 8'hF0) : f0_seen_q;
    last_data_d = pop ? dout : last_data_q;
    port_in_d = data_rd ? (empty ? last_data_q : dout)
              : stat_rd ? stat_byte(f0_seen_q, overflow_q, ~empty) : port_in_q;
  end
  always_ff @(posedge clock50)
    if (reset) begin
      port_read_q <= 1'b0;
      port_clk_q <= 1'b0;
      overflow_q <= 1'b0;
      f0_seen_q <= 1'b0;
      last_data_q <= 8'h00;
      port_in_q <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      port_read_q <= bus.port_read;
      port_clk_q <= bus.port_clk;
      overflow_q <= overflow_d;
      f0_seen_q <= f0_seen_d;
      last_data_q <= last_data_d;
      port_in_q <= port_in_d;
      irq_q <= ~empty;
    end
  assign bus.port_in = port_in_q;
  assign bus.kbd_irq = irq_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_kbd_scancode_fifo.sv
// tb_kbd_scancode_fifo: directed vectors with hand-computed expectations for the keyboard FIFO
module tb_kbd_scancode_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  kbd_scancode_fifo_if #(.DEPTH_LOG2(4)) bus ();
  kbd_scancode_fifo #(.DEPTH_LOG2(4)) dut (.clock50(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.ps2_data = b;
    bus.ps2_data_clk = 1'b1;
    @(negedge clk);
    bus.ps2_data_clk = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    bus.port_addr = a;
    bus.port_read = 1'b1;
    @(negedge clk);
    bus.port_read = 1'b0;
  endtask
  initial begin
    bus.ps2_data = '0;
    bus.ps2_data_clk = 1'b0;
    bus.port_addr = '0;
    bus.port_read = 1'b0;
    bus.port_clk = 1'b0;
    bus.port_out = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_port_in", bus.port_in, 8'h00);
    check("rst_irq", bus.kbd_irq, 0);
    check("rst_count", bus.fifo_count, 0);
    push(8'h1C);
    rd(16'h0064);
    check("t1_status", bus.port_in, 8'h01);
    check("t1_irq_set", bus.kbd_irq, 1);
    rd(16'h0060);
    check("t1_data", bus.port_in, 8'h1C);
    check("t1_count", bus.fifo_count, 0);
    @(negedge clk);
    check("t1_irq_clr", bus.kbd_irq, 0);
    push(8'hF0);
    rd(16'h0064);
    check("t2_status_f0", bus.port_in, 8'h05);
    push(8'h1C);
    rd(16'h0060);
    check("t2_pop_f0", bus.port_in, 8'hF0);
    rd(16'h0060);
    check("t2_pop_1c", bus.port_in, 8'h1C);
    rd(16'h0060);
    check("t2_empty_last", bus.port_in, 8'h1C);
    check("t2_empty_count", bus.fifo_count, 0);
    for (int i = 1; i <= 17; i++) push(8'(i));
    check("t3_count_full", bus.fifo_count, 16);
    rd(16'h0064);
    check("t3_status_ovf", bus.port_in, 8'h03);
    rd(16'h0064);
    check("t3_status_clr", bus.port_in, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      rd(16'h0060);
      check($sformatf("t3_pop%0d", i), bus.port_in, i);
    end
    check("t3_drained", bus.fifo_count, 0);
    for (int i = 1; i <= 16; i++) push(8'(i));
    @(negedge clk);
    bus.ps2_data = 8'hAA;
    bus.ps2_data_clk = 1'b1;
    bus.port_addr = 16'h0060;
    bus.port_read = 1'b1;
    @(negedge clk);
    bus.ps2_data_clk = 1'b0;
    bus.port_read = 1'b0;
    check("t4_pop_head", bus.port_in, 8'h01);
    check("t4_count", bus.fifo_count, 16);
    rd(16'h0064);
    check("t4_no_ovf", bus.port_in, 8'h01);
    for (int i = 0; i < 16; i++) begin
      rd(16'h0060);
      check($sformatf("t4_pop%0d", i), bus.port_in, i < 15 ? i + 2 : 8'hAA);
    end
    push(8'h21);
    push(8'h22);
    push(8'h23);
    @(negedge clk);
    bus.port_addr = 16'h0060;
    bus.port_read = 1'b1;
    repeat (5) @(negedge clk);
    bus.port_read = 1'b0;
    check("t5_one_pop", bus.fifo_count, 2);
    check("t5_data", bus.port_in, 8'h21);
    rd(16'h0060);
    rd(16'h0060);
    check("t5_tail", bus.port_in, 8'h23);
    push(8'h31);
    push(8'h32);
    push(8'h33);
    push(8'hF0);
    rd(16'h0064);
    check("t6_pre_status", bus.port_in, 8'h05);
    @(negedge clk);
    bus.port_addr = 16'h0064;
    bus.port_out = 8'hFF;
    bus.port_clk = 1'b1;
    bus.ps2_data = 8'h55;
    bus.ps2_data_clk = 1'b1;
    @(negedge clk);
    bus.port_clk = 1'b0;
    bus.ps2_data_clk = 1'b0;
    check("t6_flush_count", bus.fifo_count, 0);
    @(negedge clk);
    check("t6_flush_irq", bus.kbd_irq, 0);
    rd(16'h0064);
    check("t6_flush_status", bus.port_in, 8'h00);
    push(8'h41);
    push(8'h42);
    rd(16'h0064);
    check("t7_pre_port_in", bus.port_in, 8'h01);
    @(negedge clk);
    bus.ps2_data = 8'h43;
    bus.ps2_data_clk = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_count", bus.fifo_count, 0);
    check("t7_rst_port_in", bus.port_in, 8'h00);
    check("t7_rst_irq", bus.kbd_irq, 0);
    bus.ps2_data_clk = 1'b0;
    rst = 1'b0;
    rd(16'h0060);
    check("t7_rst_last_data", bus.port_in, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
